// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative 64-bit integer divider for DIV/DIVU/REM/REMU and
// their 32-bit W variants.
//
// A radix-2 restoring divider works on operand magnitudes, one quotient bit
// per cycle. Signs are reapplied in a single fix-up cycle. Divide-by-zero and
// signed overflow skip the iteration and go straight to fix-up.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  request handshake; in_ready is high only when idle
//   op                   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word                 1 = 32-bit W variant, result sign-extended to 64
//   rs1_data, rs2_data   dividend, divisor
//   rd                   destination register
//   kill                 flush of the in-flight operation (returns to idle)
//   wb_valid / wb_ready  result handshake towards the writeback port
//   wb_wen               regfile write enable (suppressed for rd = 0)
//   wb_waddr, wb_wdata   regfile write address / data
// ---------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic        kill,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_wen,
    output logic [4:0]  wb_waddr,
    output logic [63:0] wb_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched request and datapath state
    logic        op_rem_q;   // 1 = remainder result, 0 = quotient result
    logic        word_q;
    logic [4:0]  rd_q;
    logic        quo_neg_q;  // quotient must be negated in FIX
    logic        rem_neg_q;  // remainder must be negated in FIX
    logic [63:0] dvs_q;      // divisor magnitude
    logic [63:0] quo_q;      // dividend bits shifting out, quotient bits in
    logic [63:0] rem_q;      // partial remainder
    logic [6:0]  cnt_q;      // iterations still to run
    logic [63:0] res_q;      // final, sign-corrected, extended result

    // ------------------------------------------------------------------
    // Request decode: operands extended to 64 bits at the operating width,
    // then reduced to magnitudes for the unsigned core.
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [63:0] a_mag, b_mag;
    logic        div_zero, overflow, bypass;
    logic        accept;

    assign is_signed = ~op[0];
    assign a_ext     = word ? {{32{is_signed & rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
    assign b_ext     = word ? {{32{is_signed & rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
    assign a_neg     = is_signed & a_ext[63];
    assign b_neg     = is_signed & b_ext[63];
    assign a_mag     = a_neg ? (64'd0 - a_ext) : a_ext;
    assign b_mag     = b_neg ? (64'd0 - b_ext) : b_ext;
    assign div_zero  = (b_ext == 64'd0);
    // Most-negative / -1; after extension the W case is 0xFFFF_FFFF_8000_0000.
    assign overflow  = is_signed & (b_ext == {64{1'b1}}) &
                       (a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign bypass    = div_zero | overflow;
    assign accept    = (state == IDLE) & in_valid & ~kill;

    // ------------------------------------------------------------------
    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor; a clear borrow bit means the subtraction fits.
    // ------------------------------------------------------------------
    logic [64:0] trial, diff;
    logic        fits;

    assign trial = {rem_q, quo_q[63]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = ~diff[64];

    // Sign fix-up of the selected result
    logic [63:0] raw, fixed;
    logic        neg_sel;

    assign raw     = op_rem_q ? rem_q : quo_q;
    assign neg_sel = op_rem_q ? rem_neg_q : quo_neg_q;
    assign fixed   = neg_sel ? (64'd0 - raw) : raw;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; kill wins over every other transition.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) state_nxt = bypass ? FIX : CALC;
                CALC: if (cnt_q == 7'd1) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (wb_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state == IDLE);
        wb_valid = (state == DONE);
        wb_wen   = (state == DONE) & wb_ready & ~kill & (rd_q != 5'd0);
        wb_waddr = rd_q;
        wb_wdata = res_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rem_q  <= 1'b0;
            word_q    <= 1'b0;
            rd_q      <= 5'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dvs_q     <= 64'd0;
            quo_q     <= 64'd0;
            rem_q     <= 64'd0;
            cnt_q     <= 7'd0;
            res_q     <= 64'd0;
        end else if (accept) begin
            op_rem_q  <= op[1];
            word_q    <= word;
            rd_q      <= rd;
            // x / 0 yields an all-ones quotient regardless of signs.
            quo_neg_q <= (a_neg ^ b_neg) & ~div_zero;
            rem_neg_q <= a_neg;
            dvs_q     <= b_mag;
            cnt_q     <= word ? 7'd32 : 7'd64;
            // Bypass cases preload the final magnitudes so FIX only applies
            // signs: x/0 -> q = ~0, r = x; overflow -> q = x, r = 0.
            if (div_zero) begin
                quo_q <= {64{1'b1}};
                rem_q <= a_mag;
            end else if (overflow) begin
                quo_q <= a_mag;
                rem_q <= 64'd0;
            end else begin
                // W operands sit in the top half so 32 shifts consume them and
                // leave the quotient in the low half.
                quo_q <= word ? {a_mag[31:0], 32'd0} : a_mag;
                rem_q <= 64'd0;
            end
        end else if (state == CALC) begin
            rem_q <= fits ? diff[63:0] : trial[63:0];
            quo_q <= {quo_q[62:0], fits};
            cnt_q <= cnt_q - 7'd1;
        end else if (state == FIX) begin
            res_q <= word_q ? {{32{fixed[31]}}, fixed[31:0]} : fixed;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit: directed cases, random
// operations against an arithmetic reference model, backpressure, kill and
// mid-operation reset.
// ---------------------------------------------------------------------------
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [4:0]  rd;
    logic        kill;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [63:0] wb_wdata;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .word     (word),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .kill     (kill),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_wen   (wb_wen),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    // Reference: RISC-V division semantics in plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] f_op, input logic f_word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic        sgn;
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q64, r64;
        sgn = !f_op[0];
        if (f_word) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = '1;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res32 = f_op[1] ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        if (b == 64'd0) begin
            q64 = '1;
            r64 = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a;
            r64 = 64'd0;
        end else if (sgn) begin
            q64 = $signed(a) / $signed(b);
            r64 = $signed(a) % $signed(b);
        end else begin
            q64 = a / b;
            r64 = a % b;
        end
        return f_op[1] ? r64 : q64;
    endfunction

    // Cycle (counted from the accept edge) at which wb_valid is first seen.
    function automatic int ref_latency(input logic [1:0] f_op, input logic f_word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        sgn = !f_op[0];
        if (f_word) begin
            if (b[31:0] == 32'd0) return 2;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
            return 34;
        end
        if (b == 64'd0) return 2;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 2;
        return 66;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        kill     = 1'b0;
        wb_ready = 1'b0;
        op       = 2'b00;
        word     = 1'b0;
        rs1_data = 64'd0;
        rs2_data = 64'd0;
        rd       = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the unit idle; returns just after the accept edge.
    task automatic start_op(input logic [1:0] t_op, input logic t_word,
                            input logic [63:0] a, input logic [63:0] b, input logic [4:0] t_rd);
        op       = t_op;
        word     = t_word;
        rs1_data = a;
        rs2_data = b;
        rd       = t_rd;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Counts cycles after the accept edge until wb_valid, sampling at negedges.
    task automatic wait_valid(output int c, output bit ok, output bit early);
        c     = 0;
        ok    = 1'b0;
        early = 1'b0;
        while (c < 100 && !ok) begin
            @(negedge clk);
            in_valid = 1'b0;
            c++;
            if (wb_valid) ok = 1'b1;
            else if (wb_wen) early = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] t_op, input logic t_word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] t_rd,
                          input logic [63:0] exp, input int delay);
        int c;
        bit ok, early;
        start_op(t_op, t_word, a, b, t_rd);
        wait_valid(c, ok, early);
        if (!ok) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            do_reset();
            return;
        end
        check({tag, "_latency"}, 64'(c), 64'(ref_latency(t_op, t_word, a, b)));
        check({tag, "_early_wen"}, 64'(early), 64'd0);
        for (int i = 0; i < delay; i++) begin
            check({tag, "_stall_wen"}, 64'(wb_wen), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_valid"}, 64'(wb_valid), 64'd1);
            check({tag, "_stall_data"}, wb_wdata, exp);
            check({tag, "_stall_addr"}, 64'(wb_waddr), 64'(t_rd));
        end
        wb_ready = 1'b1;
        #1;
        check({tag, "_wen"}, 64'(wb_wen), 64'(t_rd != 5'd0));
        check({tag, "_data"}, wb_wdata, exp);
        check({tag, "_addr"}, 64'(wb_waddr), 64'(t_rd));
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        check({tag, "_after_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_after_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Watches for any writeback activity over a number of cycles.
    task automatic expect_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wb_valid || wb_wen) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int  c;
        bit  ok, early;
        logic [1:0]  r_op;
        logic        r_word;
        logic [63:0] r_a, r_b;
        logic [4:0]  r_rd;
        int          kind;

        // Reset state, observed while reset is held
        rst_n    = 1'b0;
        in_valid = 1'b0;
        kill     = 1'b0;
        wb_ready = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_wen",   64'(wb_wen),   64'd0);
        check("rst_wb_waddr", 64'(wb_waddr), 64'd0);
        check("rst_wb_wdata", wb_wdata,      64'd0);
        do_reset();

        // Directed cases
        run_op("div_m7_2",   OP_DIV,  1'b0, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 5'd3, 64'd2, 0);
        run_op("rem_m7_2",   OP_REM,  1'b0, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("div_5_0",    OP_DIV,  1'b0, 64'd5, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("rem_5_0",    OP_REM,  1'b0, 64'd5, 64'd0, 5'd7, 64'd5, 0);
        run_op("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 5'd8,
               64'h8000_0000_0000_0000, 0);
        run_op("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 64'd0, 0);
        run_op("divw",       OP_DIV,  1'b1, 64'h0000_0001_8000_0000, 64'd1, 5'd10,
               64'hFFFF_FFFF_8000_0000, 0);
        run_op("divuw",      OP_DIVU, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 5'd11,
               64'hFFFF_FFFF_8000_0000, 0);
        run_op("backpress",  OP_REMU, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, 3);
        run_op("rd_zero",    OP_DIVU, 1'b0, 64'd1000, 64'd10, 5'd0, 64'd100, 0);

        // Kill during CALC
        start_op(OP_DIV, 1'b0, 64'd12345, 64'd7, 5'd13);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("kill_calc_busy", 64'(in_ready), 64'd0);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        check("kill_calc_idle", 64'(in_ready), 64'd1);
        expect_quiet("kill_calc_quiet", 80);

        // Kill alongside in_valid in IDLE blocks acceptance
        op       = OP_DIVU;
        word     = 1'b0;
        rs1_data = 64'd9;
        rs2_data = 64'd0;
        rd       = 5'd14;
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_ready", 64'(in_ready), 64'd1);
        expect_quiet("kill_idle_quiet", 10);

        // Kill in DONE beats a same-cycle wb_ready
        start_op(OP_DIVU, 1'b0, 64'd50, 64'd5, 5'd15);
        wait_valid(c, ok, early);
        check("kill_done_reached", 64'(ok), 64'd1);
        if (ok) begin
            kill     = 1'b1;
            wb_ready = 1'b1;
            #1;
            check("kill_done_wen", 64'(wb_wen), 64'd0);
            @(posedge clk);
            @(negedge clk);
            kill     = 1'b0;
            wb_ready = 1'b0;
            check("kill_done_idle",  64'(in_ready), 64'd1);
            check("kill_done_valid", 64'(wb_valid), 64'd0);
        end else begin
            do_reset();
        end

        // Reset mid-operation: outputs clear immediately, nothing is written
        start_op(OP_DIV, 1'b0, 64'd999, 64'd3, 5'd17);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_wb_valid", 64'(wb_valid), 64'd0);
        check("midrst_wb_wen",   64'(wb_wen),   64'd0);
        check("midrst_wb_waddr", 64'(wb_waddr), 64'd0);
        check("midrst_wb_wdata", wb_wdata,      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("midrst_quiet", 80);
        run_op("post_rst", OP_REMU, 1'b0, 64'd100, 64'd7, 5'd18, 64'd2, 0);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_word = 1'($urandom_range(0, 1));
            r_a    = {$urandom, $urandom};
            r_b    = {$urandom, $urandom} >> $urandom_range(0, 63);
            r_rd   = 5'($urandom_range(0, 31));
            kind   = $urandom_range(0, 9);
            if (kind == 0) begin
                r_b = r_word ? {r_b[63:32], 32'd0} : 64'd0;
            end else if (kind == 1) begin
                r_a = r_word ? {r_a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                r_b = r_word ? {r_b[63:32], 32'hFFFF_FFFF} : '1;
            end else if (kind == 2) begin
                r_b = -r_b;
            end
            run_op($sformatf("rand%0d", n), r_op, r_word, r_a, r_b, r_rd,
                   ref_model(r_op, r_word, r_a, r_b), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
